tx_uart_ext: RTL and testbench
==============================

# tx_uart_ext

Parametrised UART transmitter with a built-in input FIFO and per-frame configurable format. It supports 5..DATA_BITS data bits, no/even/odd parity, and 1 or 2 stop bits. It sits between the host-side command/result path and the serial pin, and uses the shared baud-rate tick generator's `i_ticks` strobe (N_TICKS ticks per bit). Frames are sent back-to-back with no idle gap while the FIFO holds data.

## Interface
- `DATA_BITS`, 8: maximum data-word width; legal range 5..9.
- `N_TICKS`, 16: ticks per serial bit; must be ≥2.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `i_clk` in 1: single clock; all state changes on the rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_ticks` in 1: baud oversampling strobe, one cycle wide.
- `i_valid` in 1: input word valid.
- `o_ready` out 1: FIFO can accept a word.
- `i_data_in` in DATA_BITS: word to send; LSB is sent first.
- `i_data_bits` in $clog2(DATA_BITS+1): number of data bits per frame.
- `i_parity_mode` in 2: 00 = none, 01 = even, 10 = odd, 11 = treated as none.
- `i_stop_bits` in 1: 0 = one stop bit, 1 = two stop bits.
- `o_data_out` out 1: serial line; idles at 1.
- `o_tx_done` out 1: one-cycle pulse at the end of each frame.
- `o_busy` out 1: high while a frame is in progress.
- `o_fifo_count` out $clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation
- **Push:** a word is written to the FIFO on any cycle with `i_valid & o_ready`. `o_ready = (count != FIFO_DEPTH)` and depends only on the count, so a pop in the same cycle does not raise it.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** if the FIFO is non-empty, pop the head into the shift buffer and go to START. Latch `i_data_bits`, `i_parity_mode` and `i_stop_bits` at the same time. Changes to the config inputs mid-frame have no effect on the current frame.
- **Data-bit count:** an `i_data_bits` value outside 5..DATA_BITS is latched as DATA_BITS. Buffer bits at or above the latched count are ignored.
- **START:** line driven to 0 for N_TICKS ticks, then go to DATA.
- **DATA:** send buffer[0]. After N_TICKS ticks, shift right by one. After the last data bit, go to PARITY if parity is enabled, else to STOP.
- **Parity value:** even parity = XOR of the sent bits; odd parity = the inverse.
- **PARITY:** line driven to the parity bit for N_TICKS ticks, then go to STOP.
- **STOP:** line driven to 1 for N_TICKS ticks (one stop bit) or 2×N_TICKS ticks (two stop bits).
- **End of frame:** on the final STOP tick, pulse `o_tx_done`. If the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- **Tick counting:** the counter is $clog2(2×N_TICKS) bits wide, advances only when `i_ticks` is high, and clears on every bit transition.
- **Reset (asserted at any time, including mid-frame):** FSM to IDLE and FIFO flushed. Outputs take these values immediately:

| Output | Value during reset |
|---|---|
| `o_data_out` | 1 |
| `o_tx_done` | 0 |
| `o_busy` | 0 |
| `o_fifo_count` | 0 |
| `o_ready` | 1 |

  No frame is resumed after reset is released.

## Timing
- `o_data_out` is registered: it is driven from a flop updated from the next-state logic, so no combinational path exists from inputs to the pin.
- **Latency:** push accepted in cycle k with the FIFO empty and state IDLE → `o_data_out` goes to 0 in cycle k+2.
- **Frame length:** (1 + nbits + p + stop) × N_TICKS ticks, where p = 1 if parity is enabled, else 0, and stop = 1 or 2.
- `o_tx_done` is high for exactly one cycle: the cycle after the final STOP tick edge, i.e. coincident with the first cycle of the next state.
- **Back-to-back frames:** the next start bit begins in the same cycle `o_tx_done` is high, with no idle tick between frames.
- **Push and pop in the same cycle:** both take effect and the count is unchanged. A push on a full FIFO is refused (`o_ready` = 0). A pop on an empty FIFO never occurs.
- `o_busy` = (state != IDLE), registered.

## Structure
- **Shared include `uart_defs.vh`:** FSM state codes, parity-mode codes (PAR_NONE / PAR_EVEN / PAR_ODD) and stop-bit codes. The receive-side successor uses the same file.
- **Sub-module `uart_fifo`:** synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, pop, din, dout, count, full, empty. Async active-low reset. dout shows the head entry without a read delay (first-word fall-through).
- **Top:** the FSM, tick counter, shift buffer, parity accumulator and output flop.

## Test plan
- **8N1, 0xA5, `i_ticks` = 1 every cycle, N_TICKS = 16:** expect `o_data_out` bits 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. `o_tx_done` pulses at cycle 160 after the start bit.
- **7O2, word 0x41:** expect data bits 1,0,0,0,0,0,1, then parity 1, then two stop bits. Frame length 176 ticks.
- **8E1, words 0xA5 then 0x01 pushed back-to-back:** parity bits 0 then 1. The second start bit follows the first `o_tx_done` with zero gap. Exactly two done pulses.
- **FIFO full, `i_ticks` held 0:** push 6 words. The first is popped into the buffer and the next 4 fill the FIFO. On the 6th push, `o_ready` = 0 and `o_fifo_count` = 4; the 6th word is not accepted.
- **Reset mid-frame:** assert `i_reset_n` = 0 during data bit 3 with 2 words queued. `o_data_out` = 1 immediately, `o_busy` = 0, `o_fifo_count` = 0, no `o_tx_done` pulse. After release, the line stays idle until a new push.
- **Config change mid-frame:** switch `i_parity_mode` and `i_data_bits` during DATA. The current frame completes in the latched format; the next frame uses the new format.

Source files
------------

// File: rtl/tx_uart_ext_pkg.sv
// Shared UART definitions: FSM state codes, parity-mode codes, stop-bit codes.
package tx_uart_ext_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Mode 11 is treated as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/tx_uart_ext_if.sv
// Host-side word handshake into the UART transmitter FIFO.
interface tx_uart_ext_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic [DATA_BITS-1:0] i_data_in;

  modport master (output i_valid, output i_data_in, input o_ready);
  modport slave  (input i_valid, input i_data_in, output o_ready);
endinterface

// File: rtl/tx_uart_ext_fifo.sv
// First-word-fall-through synchronous FIFO; dout always shows the head entry.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset flushes the FIFO.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written at the tail on accepted pushes.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/tx_uart_ext.sv
// UART transmitter with input FIFO and per-frame data-bits/parity/stop format.
module tx_uart_ext
  import tx_uart_ext_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int N_TICKS    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_ticks,
  tx_uart_ext_if.slave                    bus,
  input  logic [$clog2(DATA_BITS+1)-1:0]  i_data_bits,
  input  logic [1:0]                      i_parity_mode,
  input  logic                            i_stop_bits,
  output logic                            o_data_out,
  output logic                            o_tx_done,
  output logic                            o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_count
);
  localparam int NB_W  = $clog2(DATA_BITS+1);
  localparam int CNT_W = $clog2(2*N_TICKS);
  localparam logic [CNT_W-1:0] LAST_ONE = CNT_W'(N_TICKS-1);
  localparam logic [CNT_W-1:0] LAST_TWO = CNT_W'(2*N_TICKS-1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [NB_W-1:0]      bit_q, bit_d;
  logic [NB_W-1:0]      nbits_q, nbits_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 stop2_q, stop2_d;
  logic                 par_q, par_d;
  logic                 data_out_q, data_out_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 fifo_pop, fifo_full, fifo_empty, load;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [CNT_W-1:0]     bit_last;
  logic                 bit_end;

  // Out-of-range widths fall back to the full word.
  function automatic logic [NB_W-1:0] clamp_bits(input logic [NB_W-1:0] req);
    if (req < NB_W'(5) || req > NB_W'(DATA_BITS)) return NB_W'(DATA_BITS);
    return req;
  endfunction

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (bus.i_valid),
    .pop       (fifo_pop),
    .din       (bus.i_data_in),
    .dout      (fifo_dout),
    .count     (o_fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.o_ready = ~fifo_full;
  assign o_data_out  = data_out_q;
  assign o_tx_done   = done_q;
  assign o_busy      = busy_q;

  // Next-state logic: bit timing, shifting, parity accumulation and line value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    nbits_d  = nbits_q;
    pmode_d  = pmode_q;
    stop2_d  = stop2_q;
    par_d    = par_q;
    done_d   = 1'b0;
    load     = 1'b0;
    fifo_pop = 1'b0;

    bit_last = (state_q == ST_STOP && stop2_q == STOP_TWO) ? LAST_TWO : LAST_ONE;
    bit_end  = i_ticks && (cnt_q == bit_last);
    if (state_q != ST_IDLE && i_ticks) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE:   if (!fifo_empty) load = 1'b1;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_q == nbits_q - 1'b1) begin
            bit_d   = '0;
            state_d = parity_enabled(pmode_q) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (!fifo_empty) load = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dout;
      nbits_d  = clamp_bits(i_data_bits);
      pmode_d  = i_parity_mode;
      stop2_d  = i_stop_bits;
      par_d    = 1'b0;
      bit_d    = '0;
      cnt_d    = '0;
      state_d  = ST_START;
    end

    case (state_d)
      ST_START:  data_out_d = 1'b0;
      ST_DATA:   data_out_d = shift_d[0];
      ST_PARITY: data_out_d = par_d ^ (pmode_d == PAR_ODD);
      default:   data_out_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      nbits_q    <= NB_W'(DATA_BITS);
      pmode_q    <= PAR_NONE;
      stop2_q    <= STOP_ONE;
      par_q      <= 1'b0;
      data_out_q <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      nbits_q    <= nbits_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
      par_q      <= par_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_tx_uart_ext.sv
// Scoreboard bench for tx_uart_ext: frames expected at push, decoded off the line.
module tb_tx_uart_ext;
  localparam int DATA_BITS  = 8;
  localparam int N_TICKS    = 16;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [15:0] bits;
    int          tot;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick_en = 1'b1;
  logic       ticks;
  logic [3:0] data_bits = 4'd8;
  logic [1:0] parity_mode = 2'b00;
  logic       stop_bits = 1'b0;
  logic       data_out, tx_done, busy;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  frame_t sb[$];

  tx_uart_ext_if #(.DATA_BITS(DATA_BITS)) bus();

  assign ticks = tick_en;
  always #5 clk = ~clk;

  tx_uart_ext #(.DATA_BITS(DATA_BITS), .N_TICKS(N_TICKS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_ticks       (ticks),
    .bus           (bus),
    .i_data_bits   (data_bits),
    .i_parity_mode (parity_mode),
    .i_stop_bits   (stop_bits),
    .o_data_out    (data_out),
    .o_tx_done     (tx_done),
    .o_busy        (busy),
    .o_fifo_count  (fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: start, LSB-first data, optional parity, stop bit(s).
  function automatic frame_t model(input logic [7:0] d, input logic [3:0] nb,
                                   input logic [1:0] pm, input logic s2);
    frame_t f;
    int n, idx;
    logic p;
    n = (nb < 4'd5 || nb > 4'd8) ? 8 : int'(nb);
    f.bits = '0;
    idx = 1;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[idx] = d[i];
      p = p ^ d[i];
      idx++;
    end
    if (pm == 2'b01) begin f.bits[idx] = p;  idx++; end
    if (pm == 2'b10) begin f.bits[idx] = ~p; idx++; end
    f.bits[idx] = 1'b1; idx++;
    if (s2) begin f.bits[idx] = 1'b1; idx++; end
    f.tot = idx;
    return f;
  endfunction

  // Line monitor: samples each bit mid-way by counting ticks, checks done timing.
  logic        mon_act = 1'b0;
  logic        done_due = 1'b0;
  int          mon_tk, mon_bit;
  logic [15:0] mon_got;
  frame_t      mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act  = 1'b0;
      done_due = 1'b0;
    end else begin
      if (done_due) begin
        chk("tx_done", tx_done, 1'b1);
        if (sb.size() != 0) chk("b2b_gap", data_out, 1'b0);
        done_due = 1'b0;
      end else begin
        chk("tx_done_spurious", tx_done, 1'b0);
      end
      if (!mon_act && data_out == 1'b0) begin
        chk("frame_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          mon_act = 1'b1;
          mon_tk  = 0;
          mon_bit = 0;
          mon_got = '0;
        end
      end
      if (mon_act && ticks) begin
        mon_tk++;
        if (mon_tk == N_TICKS/2) mon_got[mon_bit] = data_out;
        if (mon_tk == N_TICKS) begin
          mon_tk = 0;
          mon_bit++;
          if (mon_bit == mon_exp.tot) begin
            chk("frame", mon_got, mon_exp.bits);
            mon_act  = 1'b0;
            done_due = 1'b1;
          end
        end
      end
    end
  end

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] pm, input logic s2);
    data_bits   = nb;
    parity_mode = pm;
    stop_bits   = s2;
  endtask

  task automatic push(input logic [7:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.i_data_in = d;
    bus.i_valid   = 1'b1;
    while (bus.o_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      chk("push_timeout", guard, 0);
    end else begin
      @(posedge clk);
      sb.push_back(model(d, data_bits, parity_mode, stop_bits));
    end
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_act || done_due || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < budget, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int bad;
    bus.i_valid   = 1'b0;
    bus.i_data_in = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_data_out", data_out, 1'b1);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_ready", bus.o_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 8N1 0xA5 with push-to-start-bit latency
    set_cfg(4'd8, 2'b00, 1'b0);
    push(8'hA5);
    @(negedge clk);
    chk("lat_k1_line", data_out, 1'b1);
    @(negedge clk);
    chk("lat_k2_line", data_out, 1'b0);
    chk("lat_k2_busy", busy, 1'b1);
    drain(400);

    // 7O2 0x41
    set_cfg(4'd7, 2'b10, 1'b1);
    push(8'h41);
    drain(400);

    // 8E1 back-to-back
    set_cfg(4'd8, 2'b01, 1'b0);
    push(8'hA5);
    push(8'h01);
    drain(800);

    // FIFO full with ticks stalled
    tick_en = 1'b0;
    set_cfg(4'd8, 2'b00, 1'b0);
    for (int i = 1; i <= 5; i++) push(8'(i * 8'h11));
    @(negedge clk);
    chk("full_count", fifo_count, 3'd4);
    chk("full_ready", bus.o_ready, 1'b0);
    bus.i_data_in = 8'h66;
    bus.i_valid   = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
    chk("full_count_after", fifo_count, 3'd4);
    tick_en = 1'b1;
    drain(2000);

    // Config change mid-frame, then an out-of-range width
    set_cfg(4'd8, 2'b00, 1'b0);
    push(8'h3C);
    repeat (50) @(negedge clk);
    set_cfg(4'd6, 2'b01, 1'b1);
    push(8'hFF);
    drain(800);
    set_cfg(4'd2, 2'b10, 1'b0);
    push(8'h96);
    drain(400);

    // Reset during data bit 3 with two words queued
    set_cfg(4'd8, 2'b00, 1'b0);
    push(8'hC3);
    push(8'h5A);
    push(8'h0F);
    repeat (66) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_line", data_out, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_count", fifo_count, 3'd0);
    chk("mid_rst_done", tx_done, 1'b0);
    chk("mid_rst_ready", bus.o_ready, 1'b1);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (data_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("idle_after_reset", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
